// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command path: operand width, sel encoding
// and the packed command carried through the queue.
package alu_pkg;

  localparam int DW = 4;

  localparam logic [1:0] SEL_ADD = 2'b00;
  localparam logic [1:0] SEL_SUB = 2'b01;
  localparam logic [1:0] SEL_AND = 2'b10;
  localparam logic [1:0] SEL_OR  = 2'b11;

  typedef struct packed {
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [1:0]    sel;
  } alu_cmd_t;

endpackage

// File: rtl/alu_cmd_queue_if.sv
// Bundle of the command, ALU and result signals around alu_cmd_queue.
// Handshake: a transfer happens on a rising edge where valid && ready; the
// sender holds its payload stable while valid is high and ready is low.
interface alu_cmd_queue_if #(
  parameter int DEPTH = 4
);
  import alu_pkg::*;

  localparam int LW = $clog2(DEPTH + 1);

  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_a;
  logic [DW-1:0] in_b;
  logic [1:0]    in_sel;
  logic [DW-1:0] alu_a;
  logic [DW-1:0] alu_b;
  logic [1:0]    alu_sel;
  logic [DW-1:0] alu_y;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_y;
  logic [1:0]    out_sel;
  logic [LW-1:0] level;

  // Environment side: command source, ALU and result sink.
  modport master (
    output flush, in_valid, in_a, in_b, in_sel, alu_y, out_ready,
    input  in_ready, alu_a, alu_b, alu_sel, out_valid, out_y, out_sel, level
  );

  // Queue side.
  modport slave (
    input  flush, in_valid, in_a, in_b, in_sel, alu_y, out_ready,
    output in_ready, alu_a, alu_b, alu_sel, out_valid, out_y, out_sel, level
  );

endinterface

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO with push/pop/flush and an occupancy count.
// Push is refused when full and pop is ignored when empty.
module alu_cmd_fifo
  import alu_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          push,
  input  logic          pop,
  input  alu_cmd_t      din,
  output alu_cmd_t      head,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  alu_cmd_t      mem_q [DEPTH];
  alu_cmd_t      mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push;
  logic          do_pop;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    do_push  = push && !full;
    do_pop   = pop && !empty;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = din;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // Storage needs no reset: it is only observed through a non-zero count.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/alu_cmd_queue.sv
// Issue stage for the 4-bit ALU: buffers commands, drives the FIFO head onto
// the ALU and registers its result for a downstream valid/ready consumer.
module alu_cmd_queue
  import alu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input logic                  clk,
  input logic                  rst,
  alu_cmd_queue_if.slave       bus
);

  localparam int CW = $clog2(DEPTH + 1);

  alu_cmd_t      cmd_in;
  alu_cmd_t      head;
  logic [CW-1:0] fifo_count;
  logic          fifo_full;
  logic          fifo_empty;
  logic          push;
  logic          load;

  logic          out_valid_q, out_valid_d;
  logic [DW-1:0] out_y_q, out_y_d;
  logic [1:0]    out_sel_q, out_sel_d;

  always_comb begin
    cmd_in.a   = bus.in_a;
    cmd_in.b   = bus.in_b;
    cmd_in.sel = bus.in_sel;
  end

  // A full FIFO refuses the push even when a pop happens in the same cycle.
  assign bus.in_ready = !fifo_full;
  assign push         = bus.in_valid && !fifo_full;
  assign load         = !fifo_empty && (!out_valid_q || bus.out_ready);

  alu_cmd_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (bus.flush),
    .push  (push),
    .pop   (load),
    .din   (cmd_in),
    .head  (head),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign bus.alu_a   = fifo_empty ? '0 : head.a;
  assign bus.alu_b   = fifo_empty ? '0 : head.b;
  assign bus.alu_sel = fifo_empty ? '0 : head.sel;

  always_comb begin
    out_valid_d = out_valid_q;
    out_y_d     = out_y_q;
    out_sel_d   = out_sel_q;
    if (bus.flush) begin
      out_valid_d = 1'b0;
      out_y_d     = '0;
      out_sel_d   = '0;
    end else if (load) begin
      out_valid_d = 1'b1;
      out_y_d     = bus.alu_y;
      out_sel_d   = head.sel;
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_y_q     <= '0;
      out_sel_q   <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_y_q     <= out_y_d;
      out_sel_q   <= out_sel_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_y     = out_y_q;
  assign bus.out_sel   = out_sel_q;
  assign bus.level     = fifo_count;

endmodule

// File: tb/tb_alu_cmd_queue.sv
// Bench for alu_cmd_queue: behavioural ALU, scenario tasks and a scoreboard
// that checks every result handed off downstream against the pushed commands.
module tb_alu_cmd_queue;
  import alu_pkg::*;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int n_vec = 0;
  int n_err = 0;
  int n_pop = 0;

  logic [5:0] exp_q[$];

  alu_cmd_queue_if #(.DEPTH(DEPTH)) bus ();

  alu_cmd_queue #(.DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] alu_fn(input logic [3:0] a, input logic [3:0] b,
                                        input logic [1:0] sel);
    case (sel)
      SEL_ADD: alu_fn = a + b;
      SEL_SUB: alu_fn = a - b;
      SEL_AND: alu_fn = a & b;
      default: alu_fn = a | b;
    endcase
  endfunction

  assign bus.alu_y = alu_fn(bus.alu_a, bus.alu_b, bus.alu_sel);

  // Scoreboard: inputs change just after posedge, so negedge sees what the
  // next rising edge will sample.
  always @(negedge clk) begin
    if (rst || bus.flush) begin
      exp_q.delete();
    end else begin
      if (bus.out_valid && bus.out_ready) begin
        n_vec++;
        n_pop++;
        if (exp_q.size() == 0) begin
          $display("FAIL sb_unexpected got sel=%0d y=%h want no result", bus.out_sel, bus.out_y);
          n_err++;
        end else begin
          logic [5:0] e;
          e = exp_q.pop_front();
          if ({bus.out_sel, bus.out_y} !== e) begin
            $display("FAIL sb_result got sel=%0d y=%h want sel=%0d y=%h",
                     bus.out_sel, bus.out_y, e[5:4], e[3:0]);
            n_err++;
          end
        end
      end
      if (bus.in_valid && bus.in_ready)
        exp_q.push_back({bus.in_sel, alu_fn(bus.in_a, bus.in_b, bus.in_sel)});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] a, input logic [3:0] b, input logic [1:0] sel);
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_sel   = sel;
  endtask

  task automatic send(input logic [3:0] a, input logic [3:0] b, input logic [1:0] sel);
    bit done;
    done = 1'b0;
    drive(a, b, sel);
    for (int t = 0; t < 50 && !done; t++) begin
      if (bus.in_ready) done = 1'b1;
      tick();
    end
    bus.in_valid = 1'b0;
    n_vec++;
    if (!done) begin
      $display("FAIL send_timeout got in_ready=0 want 1 within 50 cycles");
      n_err++;
    end
  endtask

  task automatic drain(input int exp_pops, input int pop_base);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int t = 0; t < 100; t++) begin
      if (exp_q.size() == 0 && !bus.out_valid) break;
      tick();
    end
    n_vec++;
    if (exp_q.size() != 0 || bus.out_valid !== 1'b0) begin
      $display("FAIL drain_timeout got pending=%0d out_valid=%b want 0 0", exp_q.size(), bus.out_valid);
      n_err++;
    end
    n_vec++;
    if (n_pop - pop_base != exp_pops) begin
      $display("FAIL drain_count got %0d results want %0d", n_pop - pop_base, exp_pops);
      n_err++;
    end
  endtask

  task automatic check_idle(input string tag);
    n_vec++;
    if (bus.level !== 3'd0 || bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      $display("FAIL %s_ctrl got level=%0d in_ready=%b out_valid=%b want 0 1 0",
               tag, bus.level, bus.in_ready, bus.out_valid);
      n_err++;
    end
    n_vec++;
    if (bus.out_y !== 4'd0 || bus.out_sel !== 2'd0) begin
      $display("FAIL %s_out got y=%h sel=%0d want 0 0", tag, bus.out_y, bus.out_sel);
      n_err++;
    end
    n_vec++;
    if (bus.alu_a !== 4'd0 || bus.alu_b !== 4'd0 || bus.alu_sel !== 2'd0) begin
      $display("FAIL %s_alu got a=%h b=%h sel=%0d want 0 0 0", tag, bus.alu_a, bus.alu_b, bus.alu_sel);
      n_err++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(4'h9, 4'h3, SEL_OR);
    tick();
    tick();
    bus.in_valid = 1'b0;
    rst = 1'b0;
    check_idle("reset");
  endtask

  task automatic test_single();
    bus.out_ready = 1'b1;
    send(4'h3, 4'h5, SEL_ADD);
    n_vec++;
    if (bus.level !== 3'd1 || bus.alu_a !== 4'h3 || bus.alu_b !== 4'h5 || bus.out_valid !== 1'b0) begin
      $display("FAIL single_issue got level=%0d a=%h b=%h out_valid=%b want 1 3 5 0",
               bus.level, bus.alu_a, bus.alu_b, bus.out_valid);
      n_err++;
    end
    tick();
    n_vec++;
    if (bus.out_valid !== 1'b1 || bus.out_y !== 4'h8 || bus.out_sel !== SEL_ADD || bus.level !== 3'd0) begin
      $display("FAIL single_result got valid=%b y=%h sel=%0d level=%0d want 1 8 0 0",
               bus.out_valid, bus.out_y, bus.out_sel, bus.level);
      n_err++;
    end
    tick();
    n_vec++;
    if (bus.out_valid !== 1'b0) begin
      $display("FAIL single_release got out_valid=%b want 0", bus.out_valid);
      n_err++;
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] want_y [4];
    want_y = '{4'hD, 4'h8, 4'hD, 4'h2};
    bus.out_ready = 1'b1;
    fork
      begin
        send(4'h2, 4'h5, SEL_SUB);
        send(4'hC, 4'hA, SEL_AND);
        send(4'hC, 4'h5, SEL_OR);
        send(4'h9, 4'h9, SEL_ADD);
      end
      begin
        for (int t = 0; t < 20; t++) begin
          if (bus.out_valid) break;
          tick();
        end
        for (int i = 0; i < 4; i++) begin
          n_vec++;
          if (bus.out_valid !== 1'b1 || bus.out_y !== want_y[i]) begin
            $display("FAIL b2b_seq%0d got valid=%b y=%h want 1 %h", i, bus.out_valid, bus.out_y, want_y[i]);
            n_err++;
          end
          tick();
        end
        n_vec++;
        if (bus.out_valid !== 1'b0) begin
          $display("FAIL b2b_end got out_valid=%b want 0", bus.out_valid);
          n_err++;
        end
      end
    join
  endtask

  task automatic test_backpressure();
    int acc;
    int base;
    acc  = 0;
    base = n_pop;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      drive(4'(i + 1), 4'(i), 2'(i));
      if (bus.in_ready) acc++;
      tick();
    end
    n_vec++;
    if (acc != 5 || bus.in_ready !== 1'b0 || bus.level !== 3'd4) begin
      $display("FAIL bp_full got accepted=%0d in_ready=%b level=%0d want 5 0 4", acc, bus.in_ready, bus.level);
      n_err++;
    end
    repeat (3) tick();
    n_vec++;
    if (bus.out_valid !== 1'b1 || bus.out_y !== 4'h1 || bus.out_sel !== 2'd0 || bus.level !== 3'd4) begin
      $display("FAIL bp_hold got valid=%b y=%h sel=%0d level=%0d want 1 1 0 4",
               bus.out_valid, bus.out_y, bus.out_sel, bus.level);
      n_err++;
    end
    drain(5, base);
  endtask

  task automatic test_full_wrap();
    logic [3:0] wa [12];
    logic [3:0] wb [12];
    logic [1:0] ws [12];
    int idx;
    int base;
    for (int i = 0; i < 12; i++) begin
      wa[i] = 4'($urandom_range(0, 15));
      wb[i] = 4'($urandom_range(0, 15));
      ws[i] = 2'($urandom_range(0, 3));
    end
    base = n_pop;
    idx  = 0;
    bus.out_ready = 1'b0;
    for (int t = 0; t < 10 && bus.in_ready; t++) begin
      drive(wa[idx], wb[idx], ws[idx]);
      tick();
      idx++;
    end
    n_vec++;
    if (idx != 5) begin
      $display("FAIL wrap_fill got %0d accepted want 5", idx);
      n_err++;
    end
    drive(wa[idx], wb[idx], ws[idx]);
    bus.out_ready = 1'b1;
    n_vec++;
    if (bus.in_ready !== 1'b0) begin
      $display("FAIL wrap_full_pop got in_ready=%b want 0", bus.in_ready);
      n_err++;
    end
    tick();
    n_vec++;
    if (bus.level !== 3'd3 || bus.in_ready !== 1'b1) begin
      $display("FAIL wrap_resume got level=%0d in_ready=%b want 3 1", bus.level, bus.in_ready);
      n_err++;
    end
    while (idx < 12) begin
      send(wa[idx], wb[idx], ws[idx]);
      idx++;
    end
    drain(12, base);
  endtask

  task automatic test_flush();
    bus.out_ready = 1'b0;
    send(4'h1, 4'h1, SEL_ADD);
    send(4'h2, 4'h2, SEL_ADD);
    send(4'h3, 4'h3, SEL_ADD);
    send(4'h4, 4'h4, SEL_ADD);
    n_vec++;
    if (bus.level !== 3'd3 || bus.out_valid !== 1'b1) begin
      $display("FAIL flush_pre got level=%0d out_valid=%b want 3 1", bus.level, bus.out_valid);
      n_err++;
    end
    bus.flush     = 1'b1;
    bus.out_ready = 1'b1;
    drive(4'hF, 4'hF, SEL_OR);
    tick();
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    check_idle("flush");
    send(4'h7, 4'h4, SEL_SUB);
    tick();
    n_vec++;
    if (bus.out_valid !== 1'b1 || bus.out_y !== 4'h3 || bus.out_sel !== SEL_SUB) begin
      $display("FAIL flush_after got valid=%b y=%h sel=%0d want 1 3 1", bus.out_valid, bus.out_y, bus.out_sel);
      n_err++;
    end
    drain(1, n_pop);
  endtask

  task automatic test_reset_midstream();
    bus.out_ready = 1'b0;
    send(4'h5, 4'h6, SEL_AND);
    send(4'h7, 4'h1, SEL_SUB);
    send(4'hA, 4'h5, SEL_OR);
    rst = 1'b1;
    drive(4'h1, 4'h1, SEL_ADD);
    tick();
    rst = 1'b0;
    bus.in_valid = 1'b0;
    check_idle("rst_mid");
    tick();
    n_vec++;
    if (bus.level !== 3'd0 || bus.out_valid !== 1'b0) begin
      $display("FAIL rst_mid_drop got level=%0d out_valid=%b want 0 0", bus.level, bus.out_valid);
      n_err++;
    end
    bus.out_ready = 1'b1;
  endtask

  initial begin
    bus.flush     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_sel    = '0;
    bus.out_ready = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_full_wrap();
    test_flush();
    test_reset_midstream();
    n_vec++;
    if (exp_q.size() != 0) begin
      $display("FAIL final_queue got %0d pending want 0", exp_q.size());
      n_err++;
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
